// File: rtl/f_spsram_large_pkg.sv
// Shared constants and types for the f_spsram_large access controller.
package f_spsram_large_pkg;

    localparam int WORD_W    = 128;
    localparam int BE_W      = 16;
    localparam int RSP_DEPTH = 2;

    // One read response: issuing requester and the returned word.
    typedef struct packed {
        logic              id;
        logic [WORD_W-1:0] data;
    } rsp_t;

endpackage

// File: rtl/f_spsram_large_rsp_fifo.sv
// Two-entry response FIFO with registered storage and an occupancy count.
// Push and pop in the same cycle are both honoured.
module f_spsram_large_rsp_fifo
    import f_spsram_large_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_B,
    input  logic              push,
    input  logic              push_id,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop,
    output logic              vld,
    output logic              head_id,
    output logic [WORD_W-1:0] head_data,
    output logic [1:0]        cnt
);

    rsp_t       mem_q [RSP_DEPTH];
    rsp_t       mem_d [RSP_DEPTH];
    rsp_t       push_rsp;
    logic [1:0] cnt_q, cnt_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic       do_push, do_pop;

    assign push_rsp = rsp_t'{id: push_id, data: push_data};

    // Pop only a non-empty FIFO; push into a full FIFO only when the head leaves.
    always_comb begin
        do_pop   = pop & (cnt_q != 2'd0);
        do_push  = push & ((cnt_q != 2'(RSP_DEPTH)) | do_pop);
        cnt_d    = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        wr_ptr_d = do_push ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = do_pop  ? ~rd_ptr_q : rd_ptr_q;
    end

    // Count and pointer registers.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            cnt_q    <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    generate
        for (genvar gi = 0; gi < RSP_DEPTH; gi++) begin : g_entry
            // Load this entry when it is the tail and a push is accepted.
            always_comb begin
                mem_d[gi] = mem_q[gi];
                if (do_push && (wr_ptr_q == 1'(gi))) begin
                    mem_d[gi] = push_rsp;
                end
            end

            // Entry storage; cleared so the head reads as zero after reset.
            always_ff @(posedge CLK or negedge RST_B) begin
                if (!RST_B) begin
                    mem_q[gi] <= '0;
                end else begin
                    mem_q[gi] <= mem_d[gi];
                end
            end
        end
    endgenerate

    assign vld       = (cnt_q != 2'd0);
    assign head_id   = mem_q[rd_ptr_q].id;
    assign head_data = mem_q[rd_ptr_q].data;
    assign cnt       = cnt_q;

endmodule

// File: rtl/f_spsram_large_ctrl.sv
// Two-requester round-robin access controller for the 128-bit single-port
// f_spsram_large array. Writes are posted; reads return through a tagged
// two-entry response FIFO guarded by a credit check so nothing is ever lost.
module f_spsram_large_ctrl #(
    parameter int ADDR_WIDTH = 21,
    parameter int RSP_DEPTH  = f_spsram_large_pkg::RSP_DEPTH
) (
    input  logic                  CLK,
    input  logic                  RST_B,
    input  logic [1:0]            req_vld,
    output logic [1:0]            req_rdy,
    input  logic [1:0]            req_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [127:0]          req0_wdata,
    input  logic [127:0]          req1_wdata,
    input  logic [15:0]           req0_be,
    input  logic [15:0]           req1_be,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic                  rsp_id,
    output logic [127:0]          rsp_data,
    output logic                  sram_cen,
    output logic [15:0]           sram_wen,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic [127:0]          sram_d,
    input  logic [127:0]          sram_q
);

    import f_spsram_large_pkg::*;

    logic [ADDR_WIDTH-1:0] addr_a [2];
    logic [WORD_W-1:0]     data_a [2];
    logic [BE_W-1:0]       be_a   [2];
    logic [1:0]            eligible;
    logic [1:0]            fifo_cnt;
    logic [2:0]            credit;
    logic                  rd_ok;
    logic                  pop;
    logic                  grant;
    logic                  win;

    logic                  run_q, run_d;
    logic                  rr_ptr_q, rr_ptr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  rd_id_q, rd_id_d;
    logic [ADDR_WIDTH-1:0] a_q, a_d;
    logic [WORD_W-1:0]     wdat_q, wdat_d;

    assign addr_a[0] = req0_addr;
    assign addr_a[1] = req1_addr;
    assign data_a[0] = req0_wdata;
    assign data_a[1] = req1_wdata;
    assign be_a[0]   = req0_be;
    assign be_a[1]   = req1_be;

    // A read may only issue if the FIFO can hold it together with any read
    // already in flight, after accounting for this cycle's pop.
    assign pop    = rsp_vld & rsp_rdy;
    assign credit = {1'b0, fifo_cnt} + {2'b0, rd_pend_q} - {2'b0, pop};
    assign rd_ok  = (credit < 3'(RSP_DEPTH));

    // run_q keeps grants off while reset is asserted and until the first
    // edge after release, so req_rdy and CEN stay idle throughout reset.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            assign eligible[gi] = run_q & req_vld[gi] & (req_wr[gi] | rd_ok);
            assign req_rdy[gi]  = grant & (win == 1'(gi));
        end
    endgenerate

    // Round-robin pick: rr_ptr wins if eligible, otherwise the other requester.
    always_comb begin
        grant = 1'b0;
        win   = rr_ptr_q;
        if (eligible[rr_ptr_q]) begin
            grant = 1'b1;
            win   = rr_ptr_q;
        end else if (eligible[~rr_ptr_q]) begin
            grant = 1'b1;
            win   = ~rr_ptr_q;
        end
    end

    // SRAM strobes; address and data follow the winner and otherwise hold.
    assign sram_cen = ~grant;
    assign sram_wen = (grant & req_wr[win]) ? ~be_a[win] : '1;
    assign sram_a   = grant ? addr_a[win] : a_q;
    assign sram_d   = grant ? data_a[win] : wdat_q;

    // Next-state for arbitration pointer, read pipeline and held SRAM bus.
    always_comb begin
        run_d     = 1'b1;
        rr_ptr_d  = grant ? ~win : rr_ptr_q;
        rd_pend_d = grant & ~req_wr[win];
        rd_id_d   = grant ? win : rd_id_q;
        a_d       = grant ? addr_a[win] : a_q;
        wdat_d    = grant ? data_a[win] : wdat_q;
    end

    // Control and pipeline registers; reset drops any in-flight read.
    always_ff @(posedge CLK or negedge RST_B) begin
        if (!RST_B) begin
            run_q     <= 1'b0;
            rr_ptr_q  <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
            a_q       <= '0;
            wdat_q    <= '0;
        end else begin
            run_q     <= run_d;
            rr_ptr_q  <= rr_ptr_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
            a_q       <= a_d;
            wdat_q    <= wdat_d;
        end
    end

    // The SRAM output is valid the cycle after the read edge; capture it then.
    f_spsram_large_rsp_fifo u_rsp_fifo (
        .CLK       (CLK),
        .RST_B     (RST_B),
        .push      (rd_pend_q),
        .push_id   (rd_id_q),
        .push_data (sram_q),
        .pop       (pop),
        .vld       (rsp_vld),
        .head_id   (rsp_id),
        .head_data (rsp_data),
        .cnt       (fifo_cnt)
    );

endmodule

// File: tb/tb_f_spsram_large_ctrl.sv
// Directed bench for f_spsram_large_ctrl with a behavioural single-port SRAM.
module tb_f_spsram_large_ctrl;

    localparam int AW = 21;

    logic            CLK;
    logic            RST_B;
    logic [1:0]      req_vld;
    logic [1:0]      req_rdy;
    logic [1:0]      req_wr;
    logic [AW-1:0]   req0_addr, req1_addr;
    logic [127:0]    req0_wdata, req1_wdata;
    logic [15:0]     req0_be, req1_be;
    logic            rsp_vld;
    logic            rsp_rdy;
    logic            rsp_id;
    logic [127:0]    rsp_data;
    logic            sram_cen;
    logic [15:0]     sram_wen;
    logic [AW-1:0]   sram_a;
    logic [127:0]    sram_d;
    logic [127:0]    sram_q;

    int cmp_cnt = 0;
    int err_cnt = 0;

    f_spsram_large_ctrl #(.ADDR_WIDTH(AW), .RSP_DEPTH(2)) dut (
        .CLK        (CLK),
        .RST_B      (RST_B),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_wr     (req_wr),
        .req0_addr  (req0_addr),
        .req1_addr  (req1_addr),
        .req0_wdata (req0_wdata),
        .req1_wdata (req1_wdata),
        .req0_be    (req0_be),
        .req1_be    (req1_be),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .sram_cen   (sram_cen),
        .sram_wen   (sram_wen),
        .sram_a     (sram_a),
        .sram_d     (sram_d),
        .sram_q     (sram_q)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural SRAM: byte-masked write, Q valid the cycle after a read edge.
    logic [127:0] sram_mem [256] = '{default: '0};
    logic [127:0] sram_q_m = '0;
    assign sram_q = sram_q_m;

    always @(posedge CLK) begin
        logic [127:0] w;
        if (!sram_cen) begin
            if (sram_wen != 16'hFFFF) begin
                w = sram_mem[sram_a[7:0]];
                for (int b = 0; b < 16; b++) begin
                    if (!sram_wen[b]) w[b*8 +: 8] = sram_d[b*8 +: 8];
                end
                sram_mem[sram_a[7:0]] <= w;
            end else if (sram_wen == 16'hFFFF) begin
                sram_q_m <= sram_mem[sram_a[7:0]];
            end
        end
    end

    typedef struct {
        logic [1:0]    vld;
        logic [1:0]    wr;
        logic [AW-1:0] a0, a1;
        logic [127:0]  d0, d1;
        logic [15:0]   be0, be1;
        logic          rrdy;
        logic [1:0]    e_rdy;
        logic          e_cen;
        logic [15:0]   e_wen;
        logic [AW-1:0] e_a;
        logic          e_rvld;
        logic          e_rid;
        logic [127:0]  e_rdata;
    } vec_t;

    vec_t vec_q [$];

    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] DFF = 128'hFF;
    localparam logic [127:0] D34 = 128'h1234;

    task automatic add(input logic [1:0] vld, input logic [1:0] wr,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [127:0] d0, input logic [127:0] d1,
                       input logic [15:0] be0, input logic [15:0] be1,
                       input logic rrdy, input logic [1:0] e_rdy,
                       input logic e_cen, input logic [15:0] e_wen,
                       input logic [AW-1:0] e_a, input logic e_rvld,
                       input logic e_rid, input logic [127:0] e_rdata);
        vec_t v;
        v.vld = vld;   v.wr = wr;     v.a0 = a0;       v.a1 = a1;
        v.d0 = d0;     v.d1 = d1;     v.be0 = be0;     v.be1 = be1;
        v.rrdy = rrdy; v.e_rdy = e_rdy; v.e_cen = e_cen; v.e_wen = e_wen;
        v.e_a = e_a;   v.e_rvld = e_rvld; v.e_rid = e_rid; v.e_rdata = e_rdata;
        vec_q.push_back(v);
    endtask

    task automatic idle(input logic rrdy, input logic [AW-1:0] e_a,
                        input logic e_rvld, input logic e_rid, input logic [127:0] e_rdata);
        add(2'b00, 2'b00, '0, '0, '0, '0, '0, '0, rrdy,
            2'b00, 1'b1, 16'hFFFF, e_a, e_rvld, e_rid, e_rdata);
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] vld, input logic [1:0] wr,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic rrdy);
        req_vld = vld; req_wr = wr; req0_addr = a0; req1_addr = a1; rsp_rdy = rrdy;
        req0_wdata = '0; req1_wdata = '0; req0_be = '0; req1_be = '0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " rsp_vld"},  rsp_vld,  1'b0);
        chk({tag, " req_rdy"},  req_rdy,  2'b00);
        chk({tag, " sram_cen"}, sram_cen, 1'b1);
        chk({tag, " sram_wen"}, sram_wen, 16'hFFFF);
        chk({tag, " sram_a"},   sram_a,   '0);
        chk({tag, " sram_d"},   sram_d,   '0);
        chk({tag, " rsp_id"},   rsp_id,   1'b0);
        chk({tag, " rsp_data"}, rsp_data, '0);
    endtask

    initial begin
        // Write/read 0x10, partial write, alternating reads, full stall,
        // draining, zero-byte-enable write.
        add(2'b01, 2'b01, 'h10, 'h0, DA5, '0, 16'hFFFF, '0, 1, 2'b01, 0, 16'h0000, 'h10, 0, 0, '0);
        add(2'b10, 2'b00, 'h0, 'h10, '0, '0, '0, '0, 1, 2'b10, 0, 16'hFFFF, 'h10, 0, 0, '0);
        idle(1, 'h10, 0, 0, '0);
        idle(1, 'h10, 1, 1, DA5);
        add(2'b10, 2'b10, 'h0, 'h20, '0, DFF, '0, 16'h0001, 1, 2'b10, 0, 16'hFFFE, 'h20, 0, 0, '0);
        add(2'b01, 2'b00, 'h20, 'h0, '0, '0, '0, '0, 1, 2'b01, 0, 16'hFFFF, 'h20, 0, 0, '0);
        idle(1, 'h20, 0, 0, '0);
        idle(1, 'h20, 1, 0, DFF);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 1, 2'b10, 0, 16'hFFFF, 'h20, 0, 0, '0);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 1, 2'b01, 0, 16'hFFFF, 'h10, 0, 0, '0);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 1, 2'b10, 0, 16'hFFFF, 'h20, 1, 1, DFF);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 1, 2'b01, 0, 16'hFFFF, 'h10, 1, 0, DA5);
        idle(1, 'h10, 1, 1, DFF);
        idle(1, 'h10, 1, 0, DA5);
        idle(1, 'h10, 0, 0, '0);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 0, 2'b10, 0, 16'hFFFF, 'h20, 0, 0, '0);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 0, 2'b01, 0, 16'hFFFF, 'h10, 0, 0, '0);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 0, 2'b00, 1, 16'hFFFF, 'h10, 1, 1, DFF);
        add(2'b11, 2'b01, 'h30, 'h20, D34, '0, 16'hFFFF, '0, 0, 2'b01, 0, 16'h0000, 'h30, 1, 1, DFF);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 0, 2'b00, 1, 16'hFFFF, 'h30, 1, 1, DFF);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 1, 2'b10, 0, 16'hFFFF, 'h20, 1, 1, DFF);
        add(2'b11, 2'b00, 'h10, 'h20, '0, '0, '0, '0, 1, 2'b01, 0, 16'hFFFF, 'h10, 1, 0, DA5);
        idle(1, 'h10, 1, 1, DFF);
        idle(1, 'h10, 1, 0, DA5);
        add(2'b10, 2'b00, 'h0, 'h30, '0, '0, '0, '0, 1, 2'b10, 0, 16'hFFFF, 'h30, 0, 0, '0);
        idle(1, 'h30, 0, 0, '0);
        idle(1, 'h30, 1, 1, D34);
        idle(1, 'h30, 0, 0, '0);
        add(2'b01, 2'b01, 'h10, 'h0, '0, '0, 16'h0000, '0, 1, 2'b01, 0, 16'hFFFF, 'h10, 0, 0, '0);
        add(2'b10, 2'b00, 'h0, 'h10, '0, '0, '0, '0, 1, 2'b10, 0, 16'hFFFF, 'h10, 0, 0, '0);
        idle(1, 'h10, 0, 0, '0);
        idle(1, 'h10, 1, 1, DA5);

        // Reset with requests pending.
        RST_B = 1'b0;
        drive(2'b11, 2'b00, '0, '0, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk_reset_outputs("init_reset");
        @(posedge CLK); #1;
        RST_B = 1'b1;
        drive(2'b00, 2'b00, '0, '0, 1'b1);
        @(posedge CLK); #1;

        // Directed vector table.
        for (int i = 0; i < vec_q.size(); i++) begin
            vec_t v;
            v = vec_q[i];
            req_vld = v.vld; req_wr = v.wr; req0_addr = v.a0; req1_addr = v.a1;
            req0_wdata = v.d0; req1_wdata = v.d1; req0_be = v.be0; req1_be = v.be1;
            rsp_rdy = v.rrdy;
            @(negedge CLK);
            $display("vec %0d: rdy=%b cen=%b wen=%h a=%h rsp_vld=%b id=%b data=%h",
                     i, req_rdy, sram_cen, sram_wen, sram_a, rsp_vld, rsp_id, rsp_data);
            chk($sformatf("vec%0d req_rdy", i),  req_rdy,  v.e_rdy);
            chk($sformatf("vec%0d sram_cen", i), sram_cen, v.e_cen);
            chk($sformatf("vec%0d sram_wen", i), sram_wen, v.e_wen);
            chk($sformatf("vec%0d sram_a", i),   sram_a,   v.e_a);
            chk($sformatf("vec%0d rsp_vld", i),  rsp_vld,  v.e_rvld);
            if (v.e_rvld) begin
                chk($sformatf("vec%0d rsp_id", i),   rsp_id,   v.e_rid);
                chk($sformatf("vec%0d rsp_data", i), rsp_data, v.e_rdata);
            end
            @(posedge CLK); #1;
        end

        // Reset in the cycle after a read grant: the read is dropped and the
        // round-robin pointer returns to requester 0.
        drive(2'b01, 2'b00, 'h20, '0, 1'b1);
        @(negedge CLK);
        $display("mid-read: grant rdy=%b", req_rdy);
        chk("midread grant", req_rdy, 2'b01);
        @(posedge CLK); #1;
        RST_B = 1'b0;
        @(negedge CLK);
        $display("mid-read: in reset rsp_vld=%b cen=%b", rsp_vld, sram_cen);
        chk_reset_outputs("midread_reset");
        @(posedge CLK); #1;
        RST_B = 1'b1;
        drive(2'b00, 2'b00, '0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            $display("post-reset %0d: rsp_vld=%b cen=%b", k, rsp_vld, sram_cen);
            chk($sformatf("postreset%0d rsp_vld", k), rsp_vld, 1'b0);
            chk($sformatf("postreset%0d sram_cen", k), sram_cen, 1'b1);
            @(posedge CLK); #1;
        end
        drive(2'b11, 2'b00, 'h10, 'h20, 1'b1);
        @(negedge CLK);
        $display("post-reset first grant rdy=%b", req_rdy);
        chk("postreset first grant", req_rdy, 2'b01);
        @(posedge CLK); #1;
        drive(2'b00, 2'b00, '0, '0, 1'b1);
        repeat (3) @(posedge CLK);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
